// File: rtl/yin_pkg.sv
// Shared constants and FSM encoding for the YIN tau-sweep scheduler and its comparator.
// Defaults match a 2 kHz front end with a 20 ms maximum lag.
package yin_pkg;

   localparam int YIN_MAX_TAU     = 40;
   localparam int YIN_TAU_BITS    = 6;
   localparam int YIN_ACC_WIDTH   = 39;
   localparam int YIN_THRESH_BITS = 8;

   // 0x26 / 256 is roughly the classic YIN threshold of 0.15.
   localparam logic [YIN_THRESH_BITS-1:0] YIN_DEFAULT_THRESHOLD = 8'h26;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_RUN  = 3'd2,
      ST_EVAL = 3'd3,
      ST_DONE = 3'd4
   } yin_state_e;

endpackage

// File: rtl/yin_cmnd_compare.sv
// Division-free cumulative-mean-normalised threshold test:
// below = ((d * tau) << THRESH_BITS) < threshold * sum_new, all unsigned, full width.
module yin_cmnd_compare
   import yin_pkg::*;
#(
   parameter int ACC_WIDTH   = YIN_ACC_WIDTH,
   parameter int TAU_BITS    = YIN_TAU_BITS,
   parameter int THRESH_BITS = YIN_THRESH_BITS
)(
   input  logic [ACC_WIDTH-1:0]          d,
   input  logic [TAU_BITS-1:0]           tau,
   input  logic [THRESH_BITS-1:0]        threshold,
   input  logic [ACC_WIDTH+TAU_BITS-1:0] sum_new,
   output logic                          below
);

   localparam int PW = ACC_WIDTH + TAU_BITS;
   localparam int FW = PW + THRESH_BITS;

   logic [PW-1:0] d_tau;
   logic [FW-1:0] lhs;
   logic [FW-1:0] rhs;

   assign d_tau = PW'(d) * PW'(tau);
   assign lhs   = {d_tau, {THRESH_BITS{1'b0}}};
   assign rhs   = FW'(threshold) * FW'(sum_new);
   assign below = (lhs < rhs);

endmodule

// File: rtl/yin_tau_sweep_ctrl.sv
// Sweeps tau = 1..MAX_TAU through the difference engine, keeps the cumulative-mean sum and
// reports the first lag under threshold, or the lag of the raw minimum when none crosses.
module yin_tau_sweep_ctrl
   import yin_pkg::*;
#(
   parameter int MAX_TAU     = YIN_MAX_TAU,
   parameter int TAU_BITS    = YIN_TAU_BITS,
   parameter int ACC_WIDTH   = YIN_ACC_WIDTH,
   parameter int THRESH_BITS = YIN_THRESH_BITS
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [THRESH_BITS-1:0] threshold,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [TAU_BITS-1:0]    tau_out,
   output logic [ACC_WIDTH-1:0]   d_out,
   output logic [TAU_BITS-1:0]    diff_tau,
   output logic                   diff_reset,
   input  logic                   diff_ready,
   input  logic [ACC_WIDTH-1:0]   diff_acc,
   output yin_state_e             fsm_state
);

   localparam int SW = ACC_WIDTH + TAU_BITS;
   localparam logic [TAU_BITS-1:0] LAST_TAU = TAU_BITS'(MAX_TAU);
   localparam logic [TAU_BITS-1:0] TAU_ONE  = TAU_BITS'(1);

   yin_state_e             state;
   logic                   arm_cnt;
   logic                   seen_low;
   logic [TAU_BITS-1:0]    tau;
   logic [THRESH_BITS-1:0] thr_q;
   logic [ACC_WIDTH-1:0]   d_q;
   logic [SW-1:0]          running_sum;
   logic [ACC_WIDTH-1:0]   min_d;
   logic [TAU_BITS-1:0]    min_tau;

   logic [SW-1:0]          sum_new;
   logic                   below;
   logic                   take_min;
   logic [ACC_WIDTH-1:0]   min_d_next;
   logic [TAU_BITS-1:0]    min_tau_next;

   assign sum_new      = running_sum + SW'(d_q);
   // Strict compare so the earliest lag keeps a tie.
   assign take_min     = (d_q < min_d);
   assign min_d_next   = take_min ? d_q : min_d;
   assign min_tau_next = take_min ? tau : min_tau;
   assign fsm_state    = state;

   yin_cmnd_compare #(
      .ACC_WIDTH  (ACC_WIDTH),
      .TAU_BITS   (TAU_BITS),
      .THRESH_BITS(THRESH_BITS)
   ) u_cmp (
      .d        (d_q),
      .tau      (tau),
      .threshold(thr_q),
      .sum_new  (sum_new),
      .below    (below)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         arm_cnt     <= 1'b0;
         seen_low    <= 1'b0;
         tau         <= '0;
         thr_q       <= '0;
         d_q         <= '0;
         running_sum <= '0;
         min_d       <= '1;
         min_tau     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         tau_out     <= '0;
         d_out       <= '0;
         diff_tau    <= '0;
         diff_reset  <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               diff_reset <= 1'b1;
               busy       <= 1'b0;
               if (start) begin
                  thr_q       <= threshold;
                  tau         <= TAU_ONE;
                  diff_tau    <= TAU_ONE;
                  running_sum <= '0;
                  min_d       <= '1;
                  min_tau     <= TAU_ONE;
                  found       <= 1'b0;
                  tau_out     <= '0;
                  d_out       <= '0;
                  arm_cnt     <= 1'b0;
                  busy        <= 1'b1;
                  state       <= ST_ARM;
               end
            end

            ST_ARM: begin
               // Engine reset is held for exactly two cycles per lag.
               diff_reset <= 1'b1;
               if (arm_cnt) begin
                  diff_reset <= 1'b0;
                  seen_low   <= 1'b0;
                  state      <= ST_RUN;
               end else begin
                  arm_cnt <= 1'b1;
               end
            end

            ST_RUN: begin
               // A ready left over from the previous lag must drop before it can count.
               if (!diff_ready) begin
                  seen_low <= 1'b1;
               end else if (seen_low) begin
                  d_q   <= diff_acc;
                  state <= ST_EVAL;
               end
            end

            ST_EVAL: begin
               running_sum <= sum_new;
               if (below) begin
                  found      <= 1'b1;
                  tau_out    <= tau;
                  d_out      <= d_q;
                  done       <= 1'b1;
                  diff_reset <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  min_d   <= min_d_next;
                  min_tau <= min_tau_next;
                  if (tau == LAST_TAU) begin
                     found      <= 1'b0;
                     tau_out    <= min_tau_next;
                     d_out      <= min_d_next;
                     done       <= 1'b1;
                     diff_reset <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     tau        <= tau + TAU_ONE;
                     diff_tau   <= tau + TAU_ONE;
                     arm_cnt    <= 1'b0;
                     diff_reset <= 1'b1;
                     state      <= ST_ARM;
                  end
               end
            end

            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_yin_tau_sweep_ctrl.sv
// Directed bench for the YIN tau-sweep scheduler with a behavioural difference engine
// and a sweep-level reference model feeding an expected-result queue.
module tb_yin_tau_sweep_ctrl;
   import yin_pkg::*;

   localparam int RW = 1 + 6 + 39;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  threshold = 8'h00;
   logic        busy, done, found, diff_reset, diff_ready;
   logic [5:0]  tau_out, diff_tau;
   logic [38:0] d_out, diff_acc;
   yin_state_e  fsm_state;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   int exp_dones = 0;
   int exp_next_tau = 1;
   int n_eval = 0;
   bit prev_dr = 1'b1;

   logic [RW-1:0] exp_q[$];

   // Behavioural engine: d(tau) from a table, ready 10 cycles after reset drops,
   // or in stale mode a ready held over for 3 cycles, low, then real after 13.
   logic [38:0] tab [0:63];
   bit          stale_mode = 1'b0;
   int          cnt = 0;
   logic        eng_real;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (diff_reset) cnt <= 0;
      else if (cnt < 1000) cnt <= cnt + 1;
   end

   assign eng_real   = stale_mode ? (cnt >= 13) : (cnt >= 10);
   assign diff_ready = diff_reset ? stale_mode : (eng_real || (stale_mode && cnt < 3));
   assign diff_acc   = eng_real ? tab[diff_tau] : 39'd5;

   yin_tau_sweep_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .threshold (threshold),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .tau_out   (tau_out),
      .d_out     (d_out),
      .diff_tau  (diff_tau),
      .diff_reset(diff_reset),
      .diff_ready(diff_ready),
      .diff_acc  (diff_acc),
      .fsm_state (fsm_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Sweep-level model: walk lags with plain integer arithmetic.
   function automatic void model(input logic [7:0] thr, output bit f, output logic [5:0] t,
                                 output logic [38:0] d, output int n);
      longint unsigned sum, dk, lhs, rhs;
      sum = 0;
      f = 1'b0;
      t = 6'd1;
      d = tab[1];
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         n++;
         dk  = tab[k];
         sum = sum + dk;
         lhs = dk * longint'(k) * 256;
         rhs = longint'(thr) * sum;
         if (lhs < rhs) begin
            f = 1'b1;
            t = 6'(k);
            d = tab[k];
            return;
         end
         if (tab[k] < d) begin
            d = tab[k];
            t = 6'(k);
         end
      end
   endfunction

   task automatic fill(input logic [38:0] v);
      for (int k = 0; k < 64; k++) tab[k] = v;
   endtask

   // Compare process: result at every done pulse, lag order at every engine release.
   always @(negedge clk) begin
      logic [RW-1:0] e;
      if (!reset) begin
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("found", 64'(found), 64'(e[45]));
               chk("tau_out", 64'(tau_out), 64'(e[44:39]));
               chk("d_out", 64'(d_out), 64'(e[38:0]));
            end
         end
         if (prev_dr && !diff_reset) begin
            chk("diff_tau", 64'(diff_tau), 64'(exp_next_tau));
            exp_next_tau++;
            n_eval++;
         end
         if (!diff_reset) chk("busy_in_run", 64'(busy), 64'd1);
      end
      prev_dr = diff_reset;
   end

   task automatic begin_sweep(input logic [7:0] thr, input bit ef, input int et,
                              input logic [38:0] ed, output int n);
      bit          f;
      logic [5:0]  t;
      logic [38:0] d;
      model(thr, f, t, d, n);
      chk("model_found", 64'(f), 64'(ef));
      chk("model_tau", 64'(t), 64'(et));
      chk("model_d", 64'(d), 64'(ed));
      exp_q.push_back({f, t, d});
      exp_dones++;
      exp_next_tau = 1;
      n_eval = 0;
      @(negedge clk);
      threshold = thr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_done(input int n);
      bit got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("done_seen", 64'(got), 64'd1);
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("lags_evaluated", 64'(n_eval), 64'(n));
   endtask

   task automatic sweep(input logic [7:0] thr, input bit ef, input int et,
                        input logic [38:0] ed, input int en);
      int n;
      begin_sweep(thr, ef, et, ed, n);
      chk("model_lags", 64'(n), 64'(en));
      wait_done(n);
   endtask

   initial begin
      int  n;
      bit  hit;
      fill(39'd1000);
      tab[20] = 39'd10;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_found", 64'(found), 64'd0);
      chk("rst_tau_out", 64'(tau_out), 64'd0);
      chk("rst_d_out", 64'(d_out), 64'd0);
      chk("rst_diff_tau", 64'(diff_tau), 64'd0);
      chk("rst_diff_reset", 64'(diff_reset), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      chk("start_under_reset", 64'(busy), 64'd0);
      @(negedge clk);

      // Crossing at tau 20.
      sweep(8'h26, 1'b1, 20, 39'd10, 20);
      // Flat d: no crossing, earliest tie wins.
      fill(39'd1000);
      sweep(8'h26, 1'b0, 1, 39'd1000, 40);
      // Stale ready must not be captured.
      stale_mode = 1'b1;
      sweep(8'h26, 1'b0, 1, 39'd1000, 40);
      stale_mode = 1'b0;
      // Silent frame.
      fill(39'd0);
      sweep(8'h26, 1'b0, 1, 39'd0, 40);
      // Zero threshold can never cross.
      fill(39'd1000);
      tab[20] = 39'd10;
      sweep(8'h00, 1'b0, 20, 39'd10, 40);
      // All-ones threshold.
      fill(39'd1000);
      tab[5] = 39'd990;
      sweep(8'hFF, 1'b1, 5, 39'd990, 5);

      // Reset in the tau=7 RUN state, then a clean sweep.
      fill(39'd1000);
      tab[20] = 39'd10;
      exp_next_tau = 1;
      @(negedge clk);
      threshold = 8'h26;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         if (diff_tau == 6'd7 && !diff_reset) hit = 1'b1;
      end
      chk("reached_tau7", 64'(hit), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_diff_reset", 64'(diff_reset), 64'd1);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_tau_out", 64'(tau_out), 64'd0);
      repeat (40) @(negedge clk);
      sweep(8'h26, 1'b1, 20, 39'd10, 20);

      // Starts during busy and at DONE are ignored; mid-sweep threshold change ignored.
      begin_sweep(8'h26, 1'b1, 20, 39'd10, n);
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         if (diff_tau == 6'd3 && !diff_reset) hit = 1'b1;
      end
      chk("reached_tau3", 64'(hit), 64'd1);
      threshold = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
         @(negedge clk);
         if (done) hit = 1'b1;
      end
      chk("done_seen", 64'(hit), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_at_done_ignored", 64'(busy), 64'd0);
      chk("lags_evaluated", 64'(n_eval), 64'(n));
      repeat (40) @(negedge clk);
      chk("idle_after", 64'(busy), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(exp_dones));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
